// File: rtl/kgp_pkg.sv
// Shared KGP-RISC definitions: fetch FSM states, instruction field
// slices and the branch opcode space also decoded by the control unit.
package kgp_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    WAIT  = 3'd2,
    ISSUE = 3'd3,
    DRAIN = 3'd4
  } fetch_state_t;

  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 26;
  localparam int EXT_MSB = 10;
  localparam int EXT_LSB = 0;
  localparam int OPC_W   = 6;
  localparam int EXT_W   = 11;

  localparam logic [OPC_W-1:0] OPC_BR   = 6'd3;
  localparam logic [OPC_W-1:0] OPC_BLTZ = 6'd4;
  localparam logic [OPC_W-1:0] OPC_BZ   = 6'd5;
  localparam logic [OPC_W-1:0] OPC_BNZ  = 6'd6;
  localparam logic [OPC_W-1:0] OPC_BL   = 6'd7;
  localparam logic [OPC_W-1:0] OPC_BCY  = 6'd8;
  localparam logic [OPC_W-1:0] OPC_BNCY = 6'd9;
  localparam logic [OPC_W-1:0] OPC_BGEZ = 6'd10;
  localparam logic [OPC_W-1:0] OPC_BGTZ = 6'd11;
  localparam logic [OPC_W-1:0] OPC_BLEZ = 6'd12;
  localparam logic [OPC_W-1:0] OPC_CALL = 6'd13;
  localparam logic [OPC_W-1:0] OPC_RET  = 6'd14;

  function automatic logic [OPC_W-1:0] opc_of(
    input logic [31:0] i
  );
    return i[OPC_MSB:OPC_LSB];
  endfunction

  function automatic logic [EXT_W-1:0] ext_of(
    input logic [31:0] i
  );
    return i[EXT_MSB:EXT_LSB];
  endfunction

  function automatic logic is_branch(
    input logic [OPC_W-1:0] o
  );
    return (o >= OPC_BR) && (o <= OPC_RET);
  endfunction

endpackage

// File: rtl/kgp_pc_reg.sv
// Fetch PC register: redirect load (word aligned) beats sequential step.
// Ports: clk, rst (sync, active-low), inc, load, load_pc -> pc, pc_next, pc_step.
module kgp_pc_reg
  import kgp_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  input  logic        load,
  input  logic [31:0] load_pc,
  output logic [31:0] pc,
  output logic [31:0] pc_next,
  output logic [31:0] pc_step
);

  // 32-bit add wraps 32'hFFFF_FFFC + 4 to 0 naturally
  assign pc_step = pc + PC_STEP;

  always_comb begin
    pc_next = pc;
    if (load)
      pc_next = {load_pc[31:2], 2'b00};
    else if (inc)
      pc_next = pc_step;
  end

  always_ff @(posedge clk) begin
    if (!rst)
      pc <= RESET_PC;
    else
      pc <= pc_next;
  end

endmodule

// File: rtl/kgp_fetch_unit.sv
// KGP-RISC fetch stage: PC, imem request/ready handshake, latched instruction.
// Ports: clk, rst (sync, active-low), imem_*, stall, redirect(_pc),
// inst_valid/inst/opcode/opcode_ext/pc/pc_plus4.
// Optional KGP_FETCH_PERF_EN adds perf_issued / perf_stall counters.
module kgp_fetch_unit
  import kgp_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic             clk,
  input  logic             rst,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  input  logic             imem_ready,
  input  logic [31:0]      imem_rdata,
  input  logic             stall,
  input  logic             redirect,
  input  logic [31:0]      redirect_pc,
  output logic             inst_valid,
  output logic [31:0]      inst,
  output logic [OPC_W-1:0] opcode,
  output logic [EXT_W-1:0] opcode_ext,
  output logic [31:0]      pc,
  output logic [31:0]      pc_plus4
`ifdef KGP_FETCH_PERF_EN
  ,
  output logic [31:0]      perf_issued,
  output logic [31:0]      perf_stall
`endif
);

  fetch_state_t state;
  logic [31:0]  fpc;
  logic [31:0]  fpc_next;
  logic [31:0]  fpc_step;
  logic         adv;

  assign adv = (state == ISSUE) && !stall;

  kgp_pc_reg #(
    .RESET_PC (RESET_PC),
    .PC_STEP  (PC_STEP)
  ) u_pc (
    .clk     (clk),
    .rst     (rst),
    .inc     (adv),
    .load    (redirect),
    .load_pc (redirect_pc),
    .pc      (fpc),
    .pc_next (fpc_next),
    .pc_step (fpc_step)
  );

  // imem_req/imem_addr are registered: loaded with the next fetch PC
  // on every transition into FETCH.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      imem_req   <= 1'b0;
      imem_addr  <= RESET_PC;
      inst_valid <= 1'b0;
      inst       <= '0;
      opcode     <= '0;
      opcode_ext <= '0;
      pc         <= RESET_PC;
      pc_plus4   <= RESET_PC + PC_STEP;
    end else begin
      imem_req <= 1'b0;
      case (state)
        IDLE: begin
          state     <= FETCH;
          imem_req  <= 1'b1;
          imem_addr <= fpc_next;
        end
        FETCH: begin
          state <= redirect ? DRAIN : WAIT;
        end
        WAIT: begin
          if (redirect) begin
            if (imem_ready) begin
              state     <= FETCH;
              imem_req  <= 1'b1;
              imem_addr <= fpc_next;
            end else begin
              state <= DRAIN;
            end
          end else if (imem_ready) begin
            state      <= ISSUE;
            inst_valid <= 1'b1;
            inst       <= imem_rdata;
            opcode     <= opc_of(imem_rdata);
            opcode_ext <= ext_of(imem_rdata);
            pc         <= fpc;
            pc_plus4   <= fpc_step;
          end
        end
        ISSUE: begin
          if (redirect || !stall) begin
            state      <= FETCH;
            inst_valid <= 1'b0;
            imem_req   <= 1'b1;
            imem_addr  <= fpc_next;
          end
        end
        DRAIN: begin
          // response to a squashed fetch is dropped
          if (imem_ready) begin
            state     <= FETCH;
            imem_req  <= 1'b1;
            imem_addr <= fpc_next;
          end
        end
        default: begin
          state      <= IDLE;
          inst_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef KGP_FETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      perf_issued <= '0;
      perf_stall  <= '0;
    end else if (state == ISSUE) begin
      if (redirect || !stall)
        perf_issued <= perf_issued + 32'd1;
      else
        perf_stall <= perf_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_kgp_fetch_unit.sv
// Bench for kgp_fetch_unit: decode table, directed corner sequences,
// then random traffic against a flag-based transaction model.
module tb_kgp_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic [31:0] inst;
  logic [5:0]  opcode;
  logic [10:0] opcode_ext;
  logic [31:0] pc;
  logic [31:0] pc_plus4;

  logic        w_req;
  logic [31:0] w_addr;
  logic        w_ready;
  logic [31:0] w_rdata;
  logic        w_valid;
  logic [31:0] w_inst;
  logic [5:0]  w_opc;
  logic [10:0] w_ext;
  logic [31:0] w_pc;
  logic [31:0] w_pc4;

`ifdef KGP_FETCH_PERF_EN
  logic [31:0] perf_issued, perf_stall;
  logic [31:0] w_pi, w_ps;
`endif

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 clk = ~clk;

  kgp_fetch_unit u_dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst(inst), .opcode(opcode),
    .opcode_ext(opcode_ext), .pc(pc), .pc_plus4(pc_plus4)
`ifdef KGP_FETCH_PERF_EN
    , .perf_issued(perf_issued), .perf_stall(perf_stall)
`endif
  );

  kgp_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk(clk), .rst(rst),
    .imem_req(w_req), .imem_addr(w_addr),
    .imem_ready(w_ready), .imem_rdata(w_rdata),
    .stall(1'b0), .redirect(1'b0), .redirect_pc(32'h0),
    .inst_valid(w_valid), .inst(w_inst), .opcode(w_opc),
    .opcode_ext(w_ext), .pc(w_pc), .pc_plus4(w_pc4)
`ifdef KGP_FETCH_PERF_EN
    , .perf_issued(w_pi), .perf_stall(w_ps)
`endif
  );

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_req();
    for (int i = 0; i < 8; i++) begin
      tick();
      if (imem_req) return;
    end
    chk("req_timeout", {31'd0, imem_req}, 32'd1);
  endtask

  // assumes the current cycle is FETCH; ends observing ISSUE
  task automatic respond(input logic [31:0] d);
    tick();
    imem_ready = 1'b1;
    imem_rdata = d;
    tick();
    imem_ready = 1'b0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_req"}, {31'd0, imem_req}, 32'd0);
    chk({tag, "_addr"}, imem_addr, 32'h0);
    chk({tag, "_valid"}, {31'd0, inst_valid}, 32'd0);
    chk({tag, "_inst"}, inst, 32'h0);
    chk({tag, "_opc"}, {26'd0, opcode}, 32'd0);
    chk({tag, "_ext"}, {21'd0, opcode_ext}, 32'd0);
    chk({tag, "_pc"}, pc, 32'h0);
    chk({tag, "_pc4"}, pc_plus4, 32'h4);
`ifdef KGP_FETCH_PERF_EN
    chk({tag, "_perf_iss"}, perf_issued, 32'd0);
    chk({tag, "_perf_stl"}, perf_stall, 32'd0);
`endif
  endtask

  // Transaction-level model: flags for "just reset", "request this
  // cycle", "response outstanding", "response to be dropped",
  // "instruction presented".
  bit          m_idle, m_req, m_out, m_drop, m_hold;
  logic [31:0] m_pc, m_inst, m_ipc;
  logic [31:0] e_iss, e_stl;

  function automatic void model_reset();
    m_idle = 1; m_req = 0; m_out = 0; m_drop = 0; m_hold = 0;
    m_pc = 32'h0; m_inst = 32'h0; m_ipc = 32'h0;
    e_iss = 0; e_stl = 0;
  endfunction

  function automatic void model_step(input bit rdy, input bit stl,
                                     input bit rd, input logic [31:0] rpc,
                                     input logic [31:0] data);
    bit go = 0;
    if (m_idle) begin
      go = 1;
    end else if (m_req) begin
      m_out = 1;
      m_drop = rd;
    end else if (m_out) begin
      if (rdy) begin
        m_out = 0;
        if (m_drop || rd) go = 1;
        else begin
          m_hold = 1; m_inst = data; m_ipc = m_pc;
        end
        m_drop = 0;
      end else if (rd) begin
        m_drop = 1;
      end
    end else if (m_hold) begin
      if (rd || !stl) begin
        e_iss++;
        m_hold = 0;
        go = 1;
        if (!rd) m_pc = m_pc + 32'd4;
      end else begin
        e_stl++;
      end
    end
    if (rd) m_pc = rpc & 32'hFFFF_FFFC;
    m_idle = 0;
    m_req = go;
  endfunction

  typedef struct {
    logic [31:0] rdata;
    logic [5:0]  opc;
    logic [10:0] ext;
  } vec_t;

  vec_t tbl[5];

  initial begin
    logic [31:0] pv;
    int prev_cyc;
    bit r_ok;
    bit r_rdy, r_stl, r_rd;
    logic [31:0] r_pc, r_data;

    tbl[0] = '{32'h3C00_0000, 6'd15, 11'h000};
    tbl[1] = '{32'hFFFF_FFFF, 6'd63, 11'h7FF};
    tbl[2] = '{32'h0C00_07FF, 6'd3,  11'h7FF};
    tbl[3] = '{32'h0000_0400, 6'd0,  11'h400};
    tbl[4] = '{32'h3800_0001, 6'd14, 11'h001};

    rst = 0; imem_ready = 0; imem_rdata = 0; stall = 0;
    redirect = 0; redirect_pc = 0; w_ready = 0; w_rdata = 0;
    tick(); tick();
    chk_reset("rst0");
    chk("wrap_rst_addr", w_addr, 32'hFFFF_FFFC);
    chk("wrap_rst_pc4", w_pc4, 32'h0);

    // wrap instance
    rst = 1;
    tick();
    chk("wrap_req0", {31'd0, w_req}, 32'd1);
    chk("wrap_addr0", w_addr, 32'hFFFF_FFFC);
    tick();
    w_ready = 1; w_rdata = 32'h0400_0001;
    tick();
    w_ready = 0;
    chk("wrap_valid", {31'd0, w_valid}, 32'd1);
    chk("wrap_pc", w_pc, 32'hFFFF_FFFC);
    chk("wrap_pc4", w_pc4, 32'h0);
    tick();
    chk("wrap_req1", {31'd0, w_req}, 32'd1);
    chk("wrap_addr1", w_addr, 32'h0);

    // sequential fetch / decode table
    rst = 0; tick(); rst = 1;
    prev_cyc = 0;
    for (int k = 0; k < 5; k++) begin
      wait_req();
      chk("seq_addr", imem_addr, 32'(4 * k));
      if (k > 0) chk("seq_gap", 32'(cyc - prev_cyc), 32'd3);
      prev_cyc = cyc;
      tick();
      chk("seq_wait_valid", {31'd0, inst_valid}, 32'd0);
      imem_ready = 1; imem_rdata = tbl[k].rdata;
      tick();
      imem_ready = 0;
      chk("seq_valid", {31'd0, inst_valid}, 32'd1);
      chk("seq_inst", inst, tbl[k].rdata);
      chk("seq_opc", {26'd0, opcode}, {26'd0, tbl[k].opc});
      chk("seq_ext", {21'd0, opcode_ext}, {21'd0, tbl[k].ext});
      chk("seq_pc", pc, 32'(4 * k));
      chk("seq_pc4", pc_plus4, 32'(4 * k + 4));
    end

    // stall in ISSUE
    stall = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_valid", {31'd0, inst_valid}, 32'd1);
      chk("stall_inst", inst, tbl[4].rdata);
      chk("stall_pc", pc, 32'd16);
      chk("stall_req", {31'd0, imem_req}, 32'd0);
    end
    stall = 0;
    wait_req();
    chk("stall_next_addr", imem_addr, 32'd20);

    // redirect during WAIT, response arrives later and is dropped
    tick();
    redirect = 1; redirect_pc = 32'h100;
    tick();
    redirect = 0;
    chk("rw_valid0", {31'd0, inst_valid}, 32'd0);
    tick();
    chk("rw_valid1", {31'd0, inst_valid}, 32'd0);
    chk("rw_req1", {31'd0, imem_req}, 32'd0);
    imem_ready = 1; imem_rdata = 32'hDEAD_BEEF;
    tick();
    imem_ready = 0;
    chk("rw_valid2", {31'd0, inst_valid}, 32'd0);
    chk("rw_req2", {31'd0, imem_req}, 32'd1);
    chk("rw_addr", imem_addr, 32'h100);
    tick();
    chk("rw_inst_kept", inst, tbl[4].rdata);
    imem_ready = 1; imem_rdata = 32'h1111_2222;
    tick();
    imem_ready = 0;
    chk("rw_inst", inst, 32'h1111_2222);
    chk("rw_pc", pc, 32'h100);
    chk("rw_pc4", pc_plus4, 32'h104);

    // redirect + stall in ISSUE
    stall = 1; redirect = 1; redirect_pc = 32'h40;
    tick();
    stall = 0; redirect = 0;
    chk("rs_valid", {31'd0, inst_valid}, 32'd0);
    chk("rs_req", {31'd0, imem_req}, 32'd1);
    chk("rs_addr", imem_addr, 32'h40);
    respond(32'h2222_3333);
    chk("rs_pc", pc, 32'h40);
    stall = 1; redirect = 1; redirect_pc = 32'h43;
    tick();
    stall = 0; redirect = 0;
    chk("rs43_valid", {31'd0, inst_valid}, 32'd0);
    chk("rs43_addr", imem_addr, 32'h40);
    respond(32'h3333_4444);
    chk("rs43_inst", inst, 32'h3333_4444);
    chk("rs43_pc", pc, 32'h40);
    chk("rs43_pc4", pc_plus4, 32'h44);

    // reset in WAIT, stray ready in IDLE
    tick();
    tick();
    rst = 0; tick(); rst = 1;
    chk_reset("rstw");
    imem_ready = 1; imem_rdata = 32'hBADC_0FFE;
    tick();
    imem_ready = 0;
    chk("rstw_req", {31'd0, imem_req}, 32'd1);
    chk("rstw_addr", imem_addr, 32'h0);
    chk("rstw_inst", inst, 32'h0);
    respond(32'h5555_6666);
    chk("rstw_inst2", inst, 32'h5555_6666);
    chk("rstw_pc", pc, 32'h0);

    // random traffic vs model
    rst = 0; tick(); rst = 1;
    model_reset();
    for (int i = 0; i < 3000; i++) begin
      chk("rnd_req", {31'd0, imem_req}, {31'd0, m_req});
      if (m_req) chk("rnd_addr", imem_addr, m_pc);
      chk("rnd_valid", {31'd0, inst_valid}, {31'd0, m_hold});
      chk("rnd_inst", inst, m_inst);
      chk("rnd_opc", {26'd0, opcode}, {26'd0, m_inst[31:26]});
      chk("rnd_ext", {21'd0, opcode_ext}, {21'd0, m_inst[10:0]});
      chk("rnd_pc", pc, m_ipc);
      chk("rnd_pc4", pc_plus4, m_ipc + 32'd4);
`ifdef KGP_FETCH_PERF_EN
      chk("rnd_perf_iss", perf_issued, e_iss);
      chk("rnd_perf_stl", perf_stall, e_stl);
`endif
      r_ok = ($urandom % 97) != 0;
      r_rdy = m_out ? (($urandom % 3) == 0) : (($urandom % 8) == 0);
      r_stl = ($urandom % 3) == 0;
      r_rd = ($urandom % 9) == 0;
      r_pc = $urandom;
      r_data = $urandom;
      rst = r_ok;
      imem_ready = r_rdy; imem_rdata = r_data;
      stall = r_stl; redirect = r_rd; redirect_pc = r_pc;
      tick();
      if (r_ok) model_step(r_rdy, r_stl, r_rd, r_pc, r_data);
      else model_reset();
    end
    rst = 1; imem_ready = 0; stall = 0; redirect = 0;
    pv = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/kgp_fetch_unit.md
Name: kgp_fetch_unit

Overview:
- Instruction-fetch stage of the single-cycle KGP-RISC; sits directly upstream of the control unit.
- Holds the PC and issues word requests to instruction memory over a ready handshake.
- Latches the returned instruction and presents the opcode/opcode_ext fields, plus PC and PC+4, to decode and control.
- Accepts branch/call/return redirects from the branch logic and squashes any in-flight fetch.

Parameters:
- RESET_PC, 32'h0000_0000: PC loaded on reset.
- PC_STEP, 4: byte increment per sequential instruction.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-low reset.
- imem_req  out  1  fetch request; held one cycle per fetch.
- imem_addr  out  32  byte address of the fetch; valid while imem_req=1.
- imem_ready  in  1  response strobe; imem_rdata valid this cycle.
- imem_rdata  in  32  instruction word.
- stall  in  1  downstream cannot consume (e.g. multiply busy).
- redirect  in  1  take redirect_pc as next PC.
- redirect_pc  in  32  branch/call/return target.
- inst_valid  out  1  inst/opcode/opcode_ext/pc are valid.
- inst  out  32  latched instruction.
- opcode  out  6  inst[31:26].
- opcode_ext  out  11  inst[10:0].
- pc  out  32  address of the presented instruction.
- pc_plus4  out  32  pc+PC_STEP, mod 2^32; the link value for call.

Behaviour:
- Reset (rst=0 at posedge): state=IDLE, fetch PC=RESET_PC, imem_req=0, imem_addr=RESET_PC, inst_valid=0, inst/opcode/opcode_ext=0, pc=RESET_PC, pc_plus4=RESET_PC+4.
- Reset applies in any state and abandons any outstanding fetch. Instruction memory shares rst.
- Consumers gate regWrite/MemWrite/Branch with inst_valid, because opcode 0 / opcode_ext 0 decodes as Add.
- FSM states: IDLE, FETCH, WAIT, ISSUE, DRAIN.
  - IDLE: imem_ready ignored; next state FETCH.
  - FETCH: imem_req=1, imem_addr=fetch PC, one cycle; next state WAIT.
  - WAIT: on imem_ready, latch inst/pc/pc_plus4, set inst_valid=1, go to ISSUE. Otherwise stay in WAIT.
  - ISSUE: outputs held stable while stall=1. When stall=0, fetch PC += PC_STEP (wraps 32'hFFFF_FFFC to 0), inst_valid drops next cycle, go to FETCH.
- Minimum throughput: 3 cycles per instruction (FETCH, WAIT with ready, ISSUE with no stall).
- Redirect has priority over stall and over sequential increment in every state. Fetch PC is loaded with redirect_pc, and inst_valid clears next cycle.
  - ISSUE or IDLE: next state FETCH.
  - FETCH: the request already went out, so go to DRAIN.
  - WAIT with imem_ready in the same cycle: discard the data, go to FETCH.
  - WAIT without imem_ready: go to DRAIN.
  - DRAIN: wait for imem_ready, discard the data, go to FETCH. A further redirect in DRAIN only overwrites fetch PC.
- redirect_pc[1:0] is forced to 0.
- imem_ready outside WAIT/DRAIN is ignored.
- No combinational path from the inputs to imem_req or imem_addr.

Optional Feature:
- Macro KGP_FETCH_PERF_EN.
- Defined: adds outputs perf_issued[31:0] and perf_stall[31:0], both reset to 0, wrapping counters.
  - perf_issued increments on each ISSUE cycle with stall=0 or redirect=1.
  - perf_stall increments on each ISSUE cycle with stall=1 and redirect=0.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package kgp_pkg holds:
  - fetch state enum;
  - field slice constants: OPC_MSB=31, OPC_LSB=26, EXT_MSB=10, EXT_LSB=0;
  - OPC_W=6, EXT_W=11;
  - branch opcode constants 3–14, reused by the control unit.
- One natural sub-module: kgp_pc_reg, holding the PC register with increment/redirect muxing and wrap. The FSM stays in kgp_fetch_unit.

Test Plan:
- Sequential fetch: release rst with imem_ready 1 cycle after req.
  - Required: imem_addr sequence 0,4,8; inst_valid pulses every 3rd cycle.
  - Required: for rdata 32'h3C00_0000, opcode=6'd15 and opcode_ext=0.
- Stall: hold stall=1 for 5 cycles in ISSUE.
  - Required: inst and pc stable, no imem_req, next imem_addr=pc+4.
- Redirect during WAIT: redirect_pc=32'h100, ready 2 cycles later with 32'hDEAD_BEEF.
  - Required: DEAD_BEEF is never presented (inst_valid stays 0); next imem_addr=32'h100.
- Simultaneous redirect+stall in ISSUE: redirect_pc=32'h40.
  - Required: inst_valid=0 next cycle, imem_addr=32'h40; redirect_pc=32'h43 also yields 32'h40.
- Wrap: RESET_PC=32'hFFFF_FFFC.
  - Required: pc_plus4=0; second fetch address=0.
- Reset mid-WAIT: rst=0 one cycle, stray imem_ready in IDLE.
  - Required: all outputs at reset values, stray data ignored, first fetch at RESET_PC.
  - Required with KGP_FETCH_PERF_EN: counters read 0.
